multi_ball_motion: RTL and testbench



---
 rtl/ball_pkg.sv | 29 ++
 rtl/ball_step.sv | 74 +++++++
 rtl/multi_ball_motion.sv | 157 +++++++++++++++
 tb/tb_multi_ball_motion.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared keycodes, ball state record and FSM states for the multi-ball motion block.
// Ball coordinates and motion are held in BW-bit fields, so COORD_W may be at most BW-2.
package ball_pkg;

  localparam int BW = 16;

  localparam logic [7:0] KEY_W   = 8'h1A;
  localparam logic [7:0] KEY_A   = 8'h04;
  localparam logic [7:0] KEY_S   = 8'h16;
  localparam logic [7:0] KEY_D   = 8'h07;
  localparam logic [7:0] KEY_TAB = 8'h2B;

  typedef struct packed {
    logic        [BW-1:0] x;
    logic        [BW-1:0] y;
    logic signed [BW-1:0] mx;
    logic signed [BW-1:0] my;
  } ball_state_t;

  typedef enum logic {
    IDLE,
    UPDATE
  } fsm_state_e;

  function automatic int selWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ball_step.sv
// Combinational next state for one ball: key steering, then edge bounce.
// With BALL_WRAP_EN defined the X axis wraps around the screen instead of bouncing.
module ball_step
  import ball_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int BALL_SIZE = 4,
  parameter int STEP      = 1
) (
  input  ball_state_t cur_i,
  input  logic        steer_i,
  input  logic [7:0]  keycode_i,
  output ball_state_t next_o
);

  localparam logic signed [BW-1:0] SIZE_S     = BW'(BALL_SIZE);
  localparam logic signed [BW-1:0] STEP_S     = BW'(STEP);
  localparam logic signed [BW-1:0] XMAX_S     = BW'(X_MAX);
  localparam logic signed [BW-1:0] YMAX_S     = BW'(Y_MAX);
  localparam logic signed [BW-1:0] XSPAN_S    = BW'(X_MAX + 1);
  localparam logic        [BW-1:0] COORD_MASK = BW'((1 << COORD_W) - 1);

  logic signed [BW-1:0] posX, posY, mx, my, sumX, sumY;

  // Bounce tests use the position before the move and override any key motion.
  always_comb begin
    posX = signed'(cur_i.x);
    posY = signed'(cur_i.y);
    mx   = cur_i.mx;
    my   = cur_i.my;

    if (steer_i) begin
      case (keycode_i)
        KEY_W:   begin mx = '0;      my = -STEP_S; end
        KEY_S:   begin mx = '0;      my = STEP_S;  end
        KEY_A:   begin mx = -STEP_S; my = '0;      end
        KEY_D:   begin mx = STEP_S;  my = '0;      end
        default: ;
      endcase
    end

    if (posY + SIZE_S >= YMAX_S) begin
      my = -STEP_S;
    end else if (posY <= SIZE_S) begin
      my = STEP_S;
    end

`ifdef BALL_WRAP_EN
    sumX = posX + mx;
    if (sumX > XMAX_S) begin
      sumX = sumX - XSPAN_S;
    end else if (sumX[BW-1]) begin
      sumX = sumX + XSPAN_S;
    end
`else
    if (posX + SIZE_S >= XMAX_S) begin
      mx = -STEP_S;
    end else if (posX <= SIZE_S) begin
      mx = STEP_S;
    end
    sumX = posX + mx;
`endif

    sumY = posY + my;

    next_o.x  = sumX & COORD_MASK;
    next_o.y  = sumY & COORD_MASK;
    next_o.mx = mx;
    next_o.my = my;
  end

endmodule

// File: rtl/multi_ball_motion.sv
// Holds NUM_BALLS balls and updates one per clock in a pass launched by each vsync fall.
// Define BALL_WRAP_EN to make balls wrap horizontally instead of bouncing (see ball_step).
module multi_ball_motion
  import ball_pkg::*;
#(
  parameter int NUM_BALLS = 4,
  parameter int COORD_W   = 10,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int BALL_SIZE = 4,
  parameter int STEP      = 1,
  localparam int SEL_W    = selWidth(NUM_BALLS)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         vs,
  input  logic [7:0]                   keycode,
  output logic [NUM_BALLS*COORD_W-1:0] BallX,
  output logic [NUM_BALLS*COORD_W-1:0] BallY,
  output logic [COORD_W-1:0]           BallS,
  output logic [SEL_W-1:0]             sel,
  output logic                         busy,
  output logic [15:0]                  frame_count
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_BALLS - 1);

  fsm_state_e       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             pending_q, pending_d;
  logic [15:0]      frameCount_q, frameCount_d;
  logic             vsMeta_q, vsSync_q, vsPrev_q;
  logic             tabPrev_q;
  logic             tick, tabRise, lastBall;
  ball_state_t      balls_q [NUM_BALLS];
  ball_state_t      curBall, nextBall;

  function automatic ball_state_t initBall(input int i);
    ball_state_t b;
    b    = '0;
    b.x  = BW'((X_MAX + 1) / 2 - (NUM_BALLS - 1) * BALL_SIZE + i * 4 * BALL_SIZE);
    b.y  = BW'((Y_MAX + 1) / 2);
    return b;
  endfunction

  // vs is idle high, so the synchroniser resets high to avoid a spurious tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vsMeta_q  <= 1'b1;
      vsSync_q  <= 1'b1;
      vsPrev_q  <= 1'b1;
      tabPrev_q <= 1'b0;
    end else begin
      vsMeta_q  <= vs;
      vsSync_q  <= vsMeta_q;
      vsPrev_q  <= vsSync_q;
      tabPrev_q <= (keycode == KEY_TAB);
    end
  end

  assign tick     = vsPrev_q & ~vsSync_q;
  assign tabRise  = (keycode == KEY_TAB) && !tabPrev_q;
  assign lastBall = (idx_q == LAST_IDX);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      sel_q        <= '0;
      pending_q    <= 1'b0;
      frameCount_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      pending_q    <= pending_d;
      frameCount_q <= frameCount_d;
    end
  end

  // A queued pass restarts straight from the last ball so back-to-back passes leave no idle gap.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    frameCount_d = frameCount_q;
    sel_d        = sel_q;

    if (tabRise) begin
      sel_d = (sel_q == LAST_IDX) ? '0 : sel_q + SEL_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (tick || pending_q) begin
          state_d   = UPDATE;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      UPDATE: begin
        if (tick) begin
          pending_d = 1'b1;
        end
        if (lastBall) begin
          frameCount_d = frameCount_q + 16'd1;
          if (pending_q || tick) begin
            idx_d     = '0;
            pending_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign curBall = balls_q[idx_q];

  ball_step #(
    .COORD_W   (COORD_W),
    .X_MAX     (X_MAX),
    .Y_MAX     (Y_MAX),
    .BALL_SIZE (BALL_SIZE),
    .STEP      (STEP)
  ) u_step (
    .cur_i     (curBall),
    .steer_i   (idx_q == sel_q),
    .keycode_i (keycode),
    .next_o    (nextBall)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        balls_q[i] <= initBall(i);
      end
    end else if (state_q == UPDATE) begin
      balls_q[idx_q] <= nextBall;
    end
  end

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_pack
    assign BallX[g*COORD_W +: COORD_W] = balls_q[g].x[COORD_W-1:0];
    assign BallY[g*COORD_W +: COORD_W] = balls_q[g].y[COORD_W-1:0];
  end

  assign BallS       = COORD_W'(BALL_SIZE);
  assign sel         = sel_q;
  assign busy        = (state_q == UPDATE);
  assign frame_count = frameCount_q;

endmodule

// File: tb/tb_multi_ball_motion.sv
// Scoreboard bench for multi_ball_motion: each frame's expected result is queued when vs is
// pulsed and compared by a monitor whenever frame_count advances.
module tb_multi_ball_motion;

  localparam int NB = 4;
  localparam int CW = 10;
  localparam logic [7:0] K_D   = 8'h07;
  localparam logic [7:0] K_TAB = 8'h2B;
  localparam logic [NB*CW-1:0] RESET_X = {10'd356, 10'd340, 10'd324, 10'd308};
  localparam logic [NB*CW-1:0] RESET_Y = {10'd240, 10'd240, 10'd240, 10'd240};
`ifdef BALL_WRAP_EN
  localparam int EDGE_X = 0;
`else
  localparam int EDGE_X = 632;
`endif

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              vs = 1'b1;
  logic [7:0]        keycode = 8'h00;
  logic [NB*CW-1:0]  BallX, BallY;
  logic [CW-1:0]     BallS;
  logic [1:0]        sel;
  logic              busy;
  logic [15:0]       frame_count;

  multi_ball_motion dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .vs          (vs),
    .keycode     (keycode),
    .BallX       (BallX),
    .BallY       (BallY),
    .BallS       (BallS),
    .sel         (sel),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [NB*CW-1:0] bx;
    logic [NB*CW-1:0] by;
    logic [1:0]       sel;
    logic [15:0]      fc;
  } exp_t;

  exp_t        sbQueue[$];
  int          checks = 0;
  int          passes = 0;
  int          expX[NB];
  int          expY[NB];
  int          expMx0, expSel, expFc;
  int          busyCycles = 0, busyRun = 0, lastBusyRun = 0;
  logic [15:0] prevFc = 16'd0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
  endtask

  task automatic stepClk(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Ball 0 is the only ball ever given motion; the others stay at their reset spots.
  function automatic void advanceBall0(input bit steerRight);
    int mx, nx;
    mx = steerRight ? 1 : expMx0;
`ifdef BALL_WRAP_EN
    nx = expX[0] + mx;
    if (nx > 639) nx = nx - 640;
    else if (nx < 0) nx = nx + 640;
`else
    if (expX[0] + 4 >= 639) mx = -1;
    else if (expX[0] <= 4) mx = 1;
    nx = expX[0] + mx;
`endif
    expX[0] = nx;
    expMx0  = mx;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      e.bx[i*CW +: CW] = CW'(expX[i]);
      e.by[i*CW +: CW] = CW'(expY[i]);
    end
    e.sel = 2'(expSel);
    e.fc  = 16'(expFc);
    return e;
  endfunction

  task automatic pushFrame(input bit steerRight);
    advanceBall0(steerRight);
    expFc = (expFc + 1) % 65536;
    sbQueue.push_back(snapshot());
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sbQueue.size() != 0 && n < budget) begin
      stepClk(1);
      n++;
    end
    if (sbQueue.size() != 0) begin
      checks++;
      $display("[TB] FAIL passTimeout: %0d passes still outstanding, expected 0", sbQueue.size());
      sbQueue.delete();
    end
    stepClk(2);
  endtask

  task automatic applyStimulus(input bit steerRight);
    pushFrame(steerRight);
    vs = 1'b0;
    stepClk(2);
    vs = 1'b1;
    waitDrain(40);
  endtask

  task automatic pulseTab();
    keycode = K_TAB;
    stepClk(2);
    keycode = 8'h00;
    stepClk(2);
  endtask

  // Monitor: one completed pass per frame_count step, compared against the oldest queued frame.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      prevFc  = 16'd0;
      busyRun = 0;
    end else begin
      if (busy) begin
        busyCycles++;
        busyRun++;
      end else if (busyRun != 0) begin
        lastBusyRun = busyRun;
        busyRun     = 0;
      end
      if (frame_count !== prevFc) begin
        prevFc = frame_count;
        if (sbQueue.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpectedPass: got frame_count %0d, expected no pass", frame_count);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("passBallX", 64'(BallX), 64'(e.bx));
          checkOutput("passBallY", 64'(BallY), 64'(e.by));
          checkOutput("passSel", 64'(sel), 64'(e.sel));
          checkOutput("passFrameCount", 64'(frame_count), 64'(e.fc));
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] aborted by watchdog");
  end

  initial begin
    int b0, n;
    for (int i = 0; i < NB; i++) begin
      expX[i] = 308 + 16 * i;
      expY[i] = 240;
    end
    expMx0 = 0;
    expSel = 0;
    expFc  = 0;

    stepClk(3);
    Reset = 1'b0;
    stepClk(2);
    checkOutput("resetBallX", 64'(BallX), 64'(RESET_X));
    checkOutput("resetBallY", 64'(BallY), 64'(RESET_Y));
    checkOutput("resetSel", 64'(sel), 0);
    checkOutput("resetFrameCount", 64'(frame_count), 0);
    checkOutput("resetBusy", 64'(busy), 0);
    checkOutput("ballSize", 64'(BallS), 4);

    b0 = busyCycles;
    applyStimulus(1'b0);
    checkOutput("firstPassBusyCycles", busyCycles - b0, 4);

    keycode = K_D;
    repeat (3) applyStimulus(1'b1);
    checkOutput("steerRightX", 64'(BallX[CW-1:0]), 311);
    keycode = 8'h00;
    repeat (2) applyStimulus(1'b0);

    keycode = K_TAB;
    expSel  = 1;
    stepClk(2);
    repeat (3) applyStimulus(1'b0);
    checkOutput("tabHeldSel", 64'(sel), 1);
    keycode = 8'h00;
    stepClk(2);

    for (int k = 0; k < 4; k++) begin
      pulseTab();
      expSel = (expSel + 1) % NB;
      applyStimulus(1'b0);
    end
    checkOutput("tabPulseSel", 64'(sel), 1);
    repeat (3) begin
      pulseTab();
      expSel = (expSel + 1) % NB;
    end
    checkOutput("tabWrapSel", 64'(sel), 0);

    keycode = K_D;
    repeat (318) applyStimulus(1'b1);
    keycode = 8'h00;
    repeat (2) applyStimulus(1'b0);
    checkOutput("rightEdgeX", 64'(BallX[CW-1:0]), EDGE_X);

    // Three vs falls two cycles apart: the second queues a pass, the third is dropped.
    b0 = busyCycles;
    pushFrame(1'b0);
    pushFrame(1'b0);
    for (int k = 0; k < 3; k++) begin
      vs = 1'b0;
      stepClk(1);
      vs = 1'b1;
      stepClk(1);
    end
    waitDrain(60);
    stepClk(20);
    checkOutput("backToBackFrameCount", 64'(frame_count), 64'(expFc));
    checkOutput("backToBackBusyRun", lastBusyRun, 8);
    checkOutput("backToBackBusyCycles", busyCycles - b0, 8);

    vs = 1'b0;
    stepClk(2);
    vs = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      stepClk(1);
      n++;
    end
    checkOutput("busyBeforeReset", 64'(busy), 1);
    stepClk(1);
    Reset = 1'b1;
    stepClk(1);
    checkOutput("midPassResetBallX", 64'(BallX), 64'(RESET_X));
    checkOutput("midPassResetBallY", 64'(BallY), 64'(RESET_Y));
    checkOutput("midPassResetBusy", 64'(busy), 0);
    checkOutput("midPassResetFrameCount", 64'(frame_count), 0);
    checkOutput("midPassResetSel", 64'(sel), 0);
    Reset = 1'b0;
    for (int i = 0; i < NB; i++) begin
      expX[i] = 308 + 16 * i;
      expY[i] = 240;
    end
    expMx0 = 0;
    expSel = 0;
    expFc  = 0;
    b0 = busyCycles;
    stepClk(20);
    checkOutput("noPassAfterReset", busyCycles - b0, 0);
    checkOutput("frameCountAfterReset", 64'(frame_count), 0);
    applyStimulus(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
